relu_maxpool_stage: RTL and testbench
=====================================

Name: relu_maxpool_stage

Overview:
- Downstream neighbour of the convolution stage in the conv-layer top.
- Consumes the conv result stream: raster order, one output channel at a time, H x W values per channel, OC channels.
- Applies ReLU and 2x2 stride-2 max pooling.
- Emits pooled values with a flat write address into the pooled feature-map memory, then pulses done after the last channel.

Parameters:
- H, 28, conv output rows per channel; must be even.
- W, 28, conv output columns per channel; must be even.
- OC, 7, number of output channels streamed.
- DW, 16, signed data width of conv results and pooled outputs.
- AW, 11, output address width; must satisfy 2^AW >= OC*(H/2)*(W/2), i.e. 1372 by default.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms the stage for a new layer (OC channels).
- in_valid  in  1  conv result valid this cycle.
- in_data  in  DW  signed conv result.
- out_valid  out  1  pooled value valid this cycle.
- out_data  out  DW  pooled value, always >= 0.
- out_addr  out  AW  flat address ch*(H/2)*(W/2) + (row/2)*(W/2) + col/2.
- busy  out  1  high while in RUN.
- pool_done  out  1  one-cycle pulse after the last pooled value of channel OC-1.

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, registers and outputs 0; line buffer contents don't-care (never read before written).
- FSM states and transitions:
  - IDLE: start -> RUN, with col/row/ch counters cleared. in_valid is ignored.
  - RUN: each in_valid beat advances col. col wraps at W-1 and increments row; row wraps at H-1 and increments ch. The beat with ch=OC-1, row=H-1, col=W-1 -> DONE.
  - DONE: pool_done=1 for exactly one cycle -> IDLE. in_valid is ignored.
- start while in RUN or DONE is ignored.
- No backpressure: every in_valid beat in RUN is consumed. Gaps (in_valid=0) stall all counters; no state changes during a gap.
- Pair register, on even col: holds in_data.
- Line buffer: W/2 entries of DW bits. On odd col of an even row, write max(pair, in_data) to entry col/2.
- Output generation on odd col of an odd row:
  - m = max(linebuf[col/2], pair, in_data).
  - Next cycle: out_valid=1, out_data = (m<0) ? 0 : m, out_addr per the formula above.
  - Latency: 1 cycle from the bottom-right input beat of each 2x2 window.
- All comparisons are signed over DW bits. No width growth, no saturation.
- Output registers hold their last value when out_valid=0.
- pool_done asserts in the cycle after the final out_valid, i.e. 2 cycles after the final input beat.
- busy is 1 in RUN only.
- out_addr is computed from a running output counter incremented per emitted value, not by multiplication. It resets to 0 on start.
- Reset mid-operation: abort immediately to IDLE. No pool_done is emitted for the aborted layer. A new start is required.

Decomposition:
- Shared package cnn_pkg holds:
  - data width DW and the signed data type;
  - pooled address width derivation (clog2 of OC*(H/2)*(W/2));
  - the FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module, pool_linebuf: W/2 x DW single-write, single-read register array, combinational read by index, synchronous write with enable.
- Counters, FSM and the max/ReLU datapath stay in relu_maxpool_stage.

Test Plan:
1. Ramp, OC=1, in_data = row*28+col, continuous in_valid -> 196 outputs. addr 0 value 29; addr 1 value 31; addr 195 value 783. pool_done exactly 2 cycles after the last input beat.
2. All inputs -5 for one channel -> all 196 outputs have out_data=0. Also window {-3,-9,-1,-7} -> 0, and window {-3,4,-1,2} -> 4.
3. Default OC=7 full layer with random in_valid gaps (~30% idle) -> exactly 1372 out_valid pulses. Addresses 0..1371, strictly increasing. Values match a software ReLU+maxpool model. Single pool_done pulse.
4. start pulse mid-RUN (after 100 beats) and in_valid while IDLE -> both ignored. Output count and values are identical to the uninterrupted run.
5. rst=0 asynchronously mid-channel 3 -> within the same cycle busy=0, out_valid=0, pool_done=0. A following start plus a full layer produces a clean result starting at addr 0.
6. Signed extremes: window {-32768, 32767, 0, 1} -> 32767. Window {-32768,-32768,-32768,-32768} -> 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the conv-layer pipeline: data width, signed sample
// type, pooled-address sizing and the ReLU/max-pool FSM state encoding.
package cnn_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a flat address into the pooled feature map.
  function automatic int pool_aw(input int oc, input int h, input int w);
    return cnt_w(oc * (h / 2) * (w / 2));
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// One pooled row of partial maxima: written on even conv rows, read back on
// the following odd row to close each 2x2 window.
module pool_linebuf #(
  parameter int DEPTH = 14,
  parameter int DW    = 16,
  parameter int IW    = 4
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [IW-1:0]        wr_idx_i,
  input  logic signed [DW-1:0] wr_data_i,
  input  logic [IW-1:0]        rd_idx_i,
  output logic signed [DW-1:0] rd_data_o
);

  logic signed [DW-1:0] mem_q [DEPTH];

  // Store the top-row pair maximum for one window.
  // NOTE: the array has no reset; each entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/relu_maxpool_stage.sv
// ReLU + 2x2/stride-2 max pooling over a raster-ordered conv result stream,
// producing pooled values with a flat write address and a layer-done pulse.
module relu_maxpool_stage
  import cnn_pkg::*;
#(
  parameter int H  = 28,
  parameter int W  = 28,
  parameter int OC = 7,
  parameter int DW = DATA_W,
  parameter int AW = pool_aw(OC, H, W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [AW-1:0]        out_addr,
  output logic                 busy,
  output logic                 pool_done
);

  localparam int CW = cnt_w(W);
  localparam int RW = cnt_w(H);
  localparam int HW = cnt_w(OC);
  localparam int IW = cnt_w(W / 2);

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [HW-1:0] CH_LAST  = HW'(OC - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [HW-1:0]        ch_q, ch_d;
  logic signed [DW-1:0] pair_q;
  logic                 out_valid_q;
  logic [DW-1:0]        out_data_q;
  logic [AW-1:0]        out_addr_q;
  logic [AW-1:0]        addr_cnt_q;
  logic                 pool_done_q;

  logic                 arm;
  logic                 beat;
  logic                 last_beat;
  logic                 lb_we;
  logic                 emit;
  logic [IW-1:0]        lb_idx;
  logic signed [DW-1:0] lb_rd;
  logic signed [DW-1:0] pair_max;
  logic signed [DW-1:0] win_max;

  assign arm       = (state_q == IDLE) && start;
  assign beat      = (state_q == RUN) && in_valid;
  assign last_beat = beat && (col_q == COL_LAST) && (row_q == ROW_LAST) && (ch_q == CH_LAST);
  assign lb_we     = beat && col_q[0] && !row_q[0];
  assign emit      = beat && col_q[0] && row_q[0];
  assign lb_idx    = IW'(col_q >> 1);

  // Signed maxima: current pair, then the pair against the stored top row.
  assign pair_max = (pair_q > in_data) ? pair_q : in_data;
  assign win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;

  pool_linebuf #(
    .DEPTH (W / 2),
    .DW    (DW),
    .IW    (IW)
  ) u_linebuf (
    .clk       (clk),
    .we_i      (lb_we),
    .wr_idx_i  (lb_idx),
    .wr_data_i (pair_max),
    .rd_idx_i  (lb_idx),
    .rd_data_o (lb_rd)
  );

  // Next-state logic: arm on start, finish on the final beat of the layer.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster position counters: col -> row -> channel, stalled on gaps.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (arm) begin
      col_d = '0;
      row_d = '0;
      ch_d  = '0;
    end else if (beat) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          ch_d  = ch_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State, counters, pair register and the registered output stage.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      addr_cnt_q  <= '0;
      pool_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      out_valid_q <= emit;
      pool_done_q <= (state_q == DONE);
      if (beat && !col_q[0]) pair_q <= in_data;
      if (arm) begin
        addr_cnt_q <= '0;
      end else if (emit) begin
        out_data_q <= win_max[DW-1] ? '0 : win_max;
        out_addr_q <= addr_cnt_q;
        addr_cnt_q <= addr_cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = (state_q == RUN);
  assign pool_done = pool_done_q;

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Directed bench for relu_maxpool_stage: a reference ReLU/max-pool model
// pushes expected {addr, value} pairs as windows complete; a monitor pops and
// compares them as the DUT emits.
module tb_relu_maxpool_stage;
  import cnn_pkg::*;

  localparam int H    = 28;
  localparam int W    = 28;
  localparam int OC   = 7;
  localparam int DW   = 16;
  localparam int AW   = 11;
  localparam int PIX  = H * W;
  localparam int NOUT = OC * (H / 2) * (W / 2);

  // Special windows for channel 0, row pair 0: {top-left, top-right, bottom-left, bottom-right}.
  localparam int SP [4][4] = '{
    '{-3, -9, -1, -7},
    '{-3, 4, -1, 2},
    '{-32768, 32767, 0, 1},
    '{-32768, -32768, -32768, -32768}
  };

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  data_t         in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          pool_done;

  relu_maxpool_stage #(.H(H), .W(W), .OC(OC), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .pool_done (pool_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   frame [H][W];
  int   got [NOUT];
  int   checks = 0;
  int   passes = 0;
  int   out_cnt = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int pixel(input int mode, input int ch, input int r, input int c);
    logic signed [15:0] v;
    case (mode)
      0: return ch * 1000 + r * W + c;
      1: begin
        if (ch == 0 && r < 2 && c < 8) return SP[c / 2][r * 2 + (c % 2)];
        return -5;
      end
      default: begin
        v = 16'($urandom);
        return int'(v);
      end
    endcase
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (pool_done) done_cnt++;
      if (out_valid) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_out", int'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("out_addr", int'(out_addr), e.addr);
          check("out_data", int'($signed(out_data)), e.val);
          if (int'(out_addr) < NOUT) got[out_addr] = int'($signed(out_data));
        end
      end
    end
  end

  // Hang guard.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within the time budget");
    $fatal(1, "timeout");
  end

  // Drive one layer; start_at re-pulses start on that beat, abort_at resets on that beat.
  task automatic run_layer(input int mode, input int gap_pct, input int start_at, input int abort_at);
    int beat_n;
    int v;
    int m;
    out_cnt  = 0;
    done_cnt = 0;
    beat_n   = 0;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    for (int ch = 0; ch < OC; ch++) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          while ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            @(negedge clk);
          end
          v = pixel(mode, ch, r, c);
          frame[r][c] = v;
          in_valid = 1'b1;
          in_data  = 16'(v);
          start    = (beat_n == start_at);
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = frame[r-1][c-1];
            if (frame[r-1][c] > m) m = frame[r-1][c];
            if (frame[r][c-1] > m) m = frame[r][c-1];
            if (v > m) m = v;
            exp_q.push_back('{addr: ch * (H / 2) * (W / 2) + (r / 2) * (W / 2) + c / 2,
                              val: (m < 0) ? 0 : m});
          end
          if (beat_n == abort_at) begin
            #2 rst = 1'b0;
            #1;
            check("abort_busy", int'(busy), 0);
            check("abort_out_valid", int'(out_valid), 0);
            check("abort_pool_done", int'(pool_done), 0);
            exp_q.delete();
            in_valid = 1'b0;
            start    = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            return;
          end
          beat_n++;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("pool_done_t1", int'(pool_done), 0);
    @(negedge clk);
    check("pool_done_t2", int'(pool_done), 1);
    @(negedge clk);
    check("pool_done_t3", int'(pool_done), 0);
    check("busy_after_layer", int'(busy), 0);
    check("out_count", out_cnt, NOUT);
    check("queue_drained", exp_q.size(), 0);
    check("done_pulses", done_cnt, 1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_addr", int'(out_addr), 0);
    check("rst_pool_done", int'(pool_done), 0);
    rst = 1'b1;
    @(negedge clk);

    // Ramp, continuous input.
    run_layer(0, 0, -1, -1);
    check("ramp_addr0", got[0], 29);
    check("ramp_addr1", got[1], 31);
    check("ramp_addr195", got[195], 783);

    // Negative data and signed-extreme windows.
    run_layer(1, 0, -1, -1);
    check("neg_window", got[0], 0);
    check("mixed_window", got[1], 4);
    check("extreme_window", got[2], 32767);
    check("all_min_window", got[3], 0);
    check("all_minus5", got[100], 0);

    // Random data, ~30% idle cycles.
    run_layer(2, 30, -1, -1);

    // in_valid while idle, then a stray start mid-run.
    out_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_busy", int'(busy), 0);
    check("idle_no_output", out_cnt, 0);
    run_layer(0, 10, 100, -1);
    check("restart_addr0", got[0], 29);
    check("restart_last", got[NOUT-1], 6783);

    // Asynchronous reset in channel 3, then a clean layer.
    run_layer(2, 20, -1, 3 * PIX + 300);
    run_layer(2, 0, -1, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
